// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command sequencer: FSM states,
// the command record and the AXI response codes.
package axi4_lite_pkg;

    localparam int CMD_ADDR_WIDTH = 32;
    localparam int CMD_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Command record at the default widths; the FIFO stores the same
    // {write, addr, wdata} ordering as a flat vector so widths can be overridden.
    typedef struct packed {
        logic                      write;
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic [CMD_DATA_WIDTH-1:0] wdata;
    } cmd_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_cmd_sequencer_if.sv
// Bundle of the sequencer's command, response, master-control and bus-monitor
// signals; "slave" is the sequencer's view, "master" is whoever drives it.
interface axi4_lite_cmd_sequencer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
);

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_write;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic [1:0]               rsp_resp;

    logic                     read_start;
    logic                     write_start;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    W_data;

    logic                     mon_RVALID;
    logic                     mon_RREADY;
    logic                     mon_BVALID;
    logic                     mon_BREADY;
    logic [DATA_WIDTH-1:0]    mon_RDATA;
    logic [1:0]               mon_RRESP;
    logic [1:0]               mon_BRESP;

    logic [$clog2(DEPTH):0]   pending;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output read_start, write_start, address, W_data,
        input  mon_RVALID, mon_RREADY, mon_BVALID, mon_BREADY,
        input  mon_RDATA, mon_RRESP, mon_BRESP,
        output pending
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  read_start, write_start, address, W_data,
        output mon_RVALID, mon_RREADY, mon_BVALID, mon_BREADY,
        output mon_RDATA, mon_RRESP, mon_BRESP,
        input  pending
    );

endinterface

// File: rtl/axi4_lite_cmd_fifo.sv
// In-order command FIFO with a show-ahead head; pointers wrap modulo DEPTH
// (a power of two) and count tracks occupancy from 0 to DEPTH.
module axi4_lite_cmd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int COUNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count == COUNT_WIDTH'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // A simultaneous push and pop moves both pointers but leaves count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi4_lite_cmd_sequencer.sv
// Queues read/write commands and issues them one at a time to an AXI4-Lite
// master, watching the bus to collect each response for the upstream client.
module axi4_lite_cmd_sequencer
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    axi4_lite_cmd_sequencer_if.slave    bus
);

    localparam int CMD_WIDTH   = 1 + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

    state_t                 state;
    state_t                 next_state;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CMD_WIDTH-1:0]   fifo_in;
    logic [CMD_WIDTH-1:0]   fifo_out;
    logic [COUNT_WIDTH-1:0] fifo_count;
    logic                   held_write;
    logic                   capture_r;
    logic                   capture_b;

    // Ready depends only on stored occupancy, never on a pop in the same cycle.
    assign bus.cmd_ready = !fifo_full;
    assign push          = bus.cmd_valid && !fifo_full;
    assign fifo_in       = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    assign bus.pending   = fifo_count;

    axi4_lite_cmd_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (DEPTH)
    ) cmd_fifo (
        .clk      (ACLK),
        .rst      (ARESET),
        .push     (push),
        .pop      (pop),
        .data_in  (fifo_in),
        .data_out (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Only the channel matching the held command can complete WAIT.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture_r  = 1'b0;
        capture_b  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (held_write) begin
                    if (bus.mon_BVALID && bus.mon_BREADY) begin
                        capture_b  = 1'b1;
                        next_state = RESP;
                    end
                end else if (bus.mon_RVALID && bus.mon_RREADY) begin
                    capture_r  = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.read_start  = (state == ISSUE) && !held_write;
    assign bus.write_start = (state == ISSUE) && held_write;
    assign bus.rsp_valid   = (state == RESP);

    // Held command and response registers; address/W_data stay put until the next pop.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            held_write    <= 1'b0;
            bus.address   <= '0;
            bus.W_data    <= '0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_resp  <= OKAY;
        end else begin
            if (pop) begin
                held_write  <= fifo_out[CMD_WIDTH-1];
                bus.address <= fifo_out[CMD_WIDTH-2 -: ADDRESS_WIDTH];
                bus.W_data  <= fifo_out[CMD_WIDTH-1] ? fifo_out[DATA_WIDTH-1:0] : '0;
            end
            if (capture_r) begin
                bus.rsp_write <= 1'b0;
                bus.rsp_rdata <= bus.mon_RDATA;
                bus.rsp_resp  <= bus.mon_RRESP;
            end
            if (capture_b) begin
                bus.rsp_write <= 1'b1;
                bus.rsp_rdata <= '0;
                bus.rsp_resp  <= bus.mon_BRESP;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// Scoreboard bench for axi4_lite_cmd_sequencer: directed commands push expected
// issues/responses, a bus responder answers starts, a monitor compares outputs.
module tb_axi4_lite_cmd_sequencer;
    import axi4_lite_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } rsp_t;

    logic ACLK = 1'b0;
    logic ARESET;

    always #5 ACLK = ~ACLK;

    axi4_lite_cmd_sequencer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    axi4_lite_cmd_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    cmd_t          exp_issue_q[$];
    rsp_t          exp_rsp_q[$];
    int            checks      = 0;
    int            failures    = 0;
    int            bus_delay   = 2;
    bit            inject_stray = 1'b0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=event expected=none", name);
    endtask

    function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
        return (a[31:28] != 4'h0) ? DECERR : OKAY;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_pending"},     64'(bus.pending),     64'd0);
        check_output({tag, "_cmd_ready"},   64'(bus.cmd_ready),   64'd1);
        check_output({tag, "_read_start"},  64'(bus.read_start),  64'd0);
        check_output({tag, "_write_start"}, 64'(bus.write_start), 64'd0);
        check_output({tag, "_rsp_valid"},   64'(bus.rsp_valid),   64'd0);
        check_output({tag, "_rsp_write"},   64'(bus.rsp_write),   64'd0);
        check_output({tag, "_rsp_rdata"},   64'(bus.rsp_rdata),   64'd0);
        check_output({tag, "_rsp_resp"},    64'(bus.rsp_resp),    64'd0);
        check_output({tag, "_address"},     64'(bus.address),     64'd0);
        check_output({tag, "_W_data"},      64'(bus.W_data),      64'd0);
    endtask

    // Holds cmd_valid until accepted; returns just after the accepting edge.
    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp);
        int budget;
        exp_issue_q.push_back('{write: w, addr: a, wdata: (w ? d : 32'h0)});
        exp_rsp_q.push_back('{write: w, rdata: exp_rdata, resp: exp_resp});
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        budget = 0;
        forever begin
            if (bus.cmd_ready) begin
                @(posedge ACLK);
                break;
            end
            budget++;
            if (budget > 300) begin
                report_fail("cmd_accept_timeout");
                break;
            end
            @(negedge ACLK);
        end
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (exp_rsp_q.size() != 0 && budget < 2000) begin
            @(negedge ACLK);
            budget++;
        end
        if (exp_rsp_q.size() != 0) begin
            report_fail("response_timeout");
            exp_rsp_q.delete();
            exp_issue_q.delete();
        end
        repeat (3) @(negedge ACLK);
    endtask

    task automatic apply_stimulus();
        int  budget;
        bit  saw_activity;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        ARESET        = 1'b1;
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);

        // Write with latency check: accepted in N, start only in N+2
        send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, OKAY);
        @(negedge ACLK);
        check_output("latency_n1_write_start", 64'(bus.write_start), 64'd0);
        @(negedge ACLK);
        check_output("latency_n2_write_start", 64'(bus.write_start), 64'd1);
        check_output("latency_n2_address", 64'(bus.address), 64'h10);
        check_output("latency_n2_W_data", 64'(bus.W_data), 64'hDEADBEEF);
        wait_idle();

        send_cmd(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, OKAY);
        send_cmd(1'b1, 32'h24, 32'h12345678, 32'h0, OKAY);
        send_cmd(1'b0, 32'h24, 32'hFFFF_FFFF, 32'h12345678, OKAY);
        send_cmd(1'b0, 32'h30, 32'h0, 32'h0, OKAY);
        send_cmd(1'b1, 32'h1000_0040, 32'h0000_A5A5, 32'h0, DECERR);
        send_cmd(1'b0, 32'h1000_0040, 32'h0, 32'h0, DECERR);
        wait_idle();

        // Stray B handshake during a read
        inject_stray = 1'b1;
        bus_delay    = 4;
        send_cmd(1'b0, 32'h24, 32'h0, 32'h12345678, OKAY);
        wait_idle();
        inject_stray = 1'b0;
        bus_delay    = 2;

        // Response stall for 10 cycles
        @(posedge ACLK);
        #1;
        bus.rsp_ready = 1'b0;
        send_cmd(1'b1, 32'h40, 32'h55AA55AA, 32'h0, OKAY);
        send_cmd(1'b0, 32'h40, 32'h0, 32'h55AA55AA, OKAY);
        budget = 0;
        while (!bus.rsp_valid && budget < 100) begin
            @(negedge ACLK);
            budget++;
        end
        check_output("stall_rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
        check_output("stall_pending", 64'(bus.pending), 64'd1);
        repeat (10) @(negedge ACLK);
        @(posedge ACLK);
        #1;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Back-pressure: fill the FIFO while the first command sits in WAIT
        bus_delay = 20;
        send_cmd(1'b1, 32'h50, 32'h1, 32'h0, OKAY);
        repeat (3) @(negedge ACLK);
        send_cmd(1'b0, 32'h50, 32'h0, 32'h1, OKAY);
        send_cmd(1'b1, 32'h54, 32'h2, 32'h0, OKAY);
        send_cmd(1'b1, 32'h58, 32'h3, 32'h0, OKAY);
        send_cmd(1'b0, 32'h58, 32'h0, 32'h3, OKAY);
        @(negedge ACLK);
        check_output("full_pending", 64'(bus.pending), 64'd4);
        check_output("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        send_cmd(1'b0, 32'h54, 32'h0, 32'h2, OKAY);
        @(negedge ACLK);
        check_output("refill_pending", 64'(bus.pending), 64'd4);
        wait_idle();

        // Reset while in WAIT with two commands queued
        send_cmd(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, OKAY);
        repeat (4) @(negedge ACLK);
        send_cmd(1'b1, 32'h60, 32'h77, 32'h0, OKAY);
        send_cmd(1'b0, 32'h60, 32'h0, 32'h77, OKAY);
        @(negedge ACLK);
        check_output("pre_reset_pending", 64'(bus.pending), 64'd2);
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        exp_issue_q.delete();
        exp_rsp_q.delete();
        @(negedge ACLK);
        check_reset_outputs("reset_in_wait");
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        saw_activity = 1'b0;
        repeat (30) begin
            @(negedge ACLK);
            if (bus.rsp_valid || bus.read_start || bus.write_start) saw_activity = 1'b1;
        end
        check_output("no_activity_after_reset", 64'(saw_activity), 64'd0);
        check_output("post_reset_pending", 64'(bus.pending), 64'd0);

        // Recovery after reset
        bus_delay = 2;
        send_cmd(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, OKAY);
        wait_idle();
    endtask

    // Bus responder: answers each start after bus_delay cycles in WAIT
    initial begin : responder
        logic          is_write;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            aborted;
        bus.mon_RVALID = 1'b0;
        bus.mon_RREADY = 1'b0;
        bus.mon_BVALID = 1'b0;
        bus.mon_BREADY = 1'b0;
        bus.mon_RDATA  = '0;
        bus.mon_RRESP  = OKAY;
        bus.mon_BRESP  = OKAY;
        forever begin
            @(negedge ACLK);
            if (!ARESET && (bus.read_start || bus.write_start)) begin
                is_write = bus.write_start;
                a        = bus.address;
                d        = bus.W_data;
                aborted  = 1'b0;
                for (int n = 0; n < bus_delay; n++) begin
                    @(negedge ACLK);
                    if (ARESET) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (inject_stray && !is_write && n == 0) begin
                        bus.mon_BVALID = 1'b1;
                        bus.mon_BREADY = 1'b1;
                        bus.mon_BRESP  = SLVERR;
                    end else if (inject_stray && !is_write && n == 1) begin
                        bus.mon_BVALID = 1'b0;
                        bus.mon_BREADY = 1'b0;
                        bus.mon_BRESP  = OKAY;
                        check_output("stray_b_ignored", 64'(bus.rsp_valid), 64'd0);
                    end
                end
                bus.mon_BVALID = 1'b0;
                bus.mon_BREADY = 1'b0;
                if (!aborted) begin
                    check_output("wait_address_held", 64'(bus.address), 64'(a));
                    check_output("wait_W_data_held", 64'(bus.W_data), 64'(d));
                    if (is_write) begin
                        if (resp_of(a) == OKAY) mem[a] = d;
                        bus.mon_BRESP  = resp_of(a);
                        bus.mon_BVALID = 1'b1;
                        bus.mon_BREADY = 1'b1;
                    end else begin
                        bus.mon_RDATA  = mem.exists(a) ? mem[a] : '0;
                        bus.mon_RRESP  = resp_of(a);
                        bus.mon_RVALID = 1'b1;
                        bus.mon_RREADY = 1'b1;
                    end
                    @(negedge ACLK);
                end
                bus.mon_RVALID = 1'b0;
                bus.mon_RREADY = 1'b0;
                bus.mon_BVALID = 1'b0;
                bus.mon_BREADY = 1'b0;
                bus.mon_RDATA  = '0;
            end
        end
    end

    // Monitor: compares start pulses and responses against the scoreboard
    initial begin : monitor
        logic prev_start;
        logic prev_stall;
        rsp_t prev_rsp;
        rsp_t got_rsp;
        rsp_t exp_rsp;
        cmd_t exp_cmd;
        prev_start = 1'b0;
        prev_stall = 1'b0;
        prev_rsp   = '0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                prev_start = 1'b0;
                prev_stall = 1'b0;
            end else begin
                got_rsp = '{write: bus.rsp_write, rdata: bus.rsp_rdata, resp: bus.rsp_resp};
                if (bus.read_start || bus.write_start) begin
                    check_output("start_onehot", 64'(bus.read_start && bus.write_start), 64'd0);
                    check_output("start_single_pulse", 64'(prev_start), 64'd0);
                    if (exp_issue_q.size() == 0) begin
                        report_fail("unexpected_start");
                    end else begin
                        exp_cmd = exp_issue_q.pop_front();
                        check_output("issue_kind", 64'(bus.write_start), 64'(exp_cmd.write));
                        check_output("issue_address", 64'(bus.address), 64'(exp_cmd.addr));
                        check_output("issue_W_data", 64'(bus.W_data), 64'(exp_cmd.wdata));
                    end
                end
                if (prev_stall) begin
                    check_output("stall_rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
                    check_output("stall_rsp_stable", 64'(got_rsp), 64'(prev_rsp));
                    check_output("stall_no_start", 64'(bus.read_start || bus.write_start), 64'd0);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_rsp_q.size() == 0) begin
                        report_fail("unexpected_rsp");
                    end else begin
                        exp_rsp = exp_rsp_q.pop_front();
                        check_output("rsp_write", 64'(got_rsp.write), 64'(exp_rsp.write));
                        check_output("rsp_rdata", 64'(got_rsp.rdata), 64'(exp_rsp.rdata));
                        check_output("rsp_resp", 64'(got_rsp.resp), 64'(exp_rsp.resp));
                    end
                end
                prev_start = bus.read_start || bus.write_start;
                prev_stall = bus.rsp_valid && !bus.rsp_ready;
                prev_rsp   = got_rsp;
            end
        end
    end

    initial begin : main
        apply_stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
